uart_cmd_parser: RTL and testbench
==================================

# uart_cmd_parser

Register-access command parser sitting directly downstream of the UART FIFO wrapper. It pops received bytes from the RX FIFO and assembles 5-byte command frames. It issues single-cycle register write/read strobes onto the DMM control register bus and pushes a 3-byte response frame into the TX FIFO. This block is the only host-side consumer of the UART link.

## Interface
Parameters:
- pSyncByte, 8'hA5, frame start marker.
- pRespByte, 8'h5A, response start marker.
- pTimeoutCycles, 120_000, inter-byte timeout in iClk cycles (10 ms at 12 MHz). Must be ≥2.

Ports:
- iClk  in  1  system clock.
- iResetn  in  1  synchronous, active-high reset (name kept for codebase consistency; high = reset).
- iRxByte  in  8  RX FIFO head byte; valid whenever iRxEmpty=0 (first-word fall-through).
- iRxEmpty  in  1  RX FIFO empty.
- oRxRead  out  1  pop RX FIFO head; 1-cycle pulse.
- oTxByte  out  8  byte to TX FIFO.
- oTxWrite  out  1  push oTxByte; 1-cycle pulse.
- iTxFull  in  1  TX FIFO full.
- oRegAddr  out  8  register address.
- oRegWData  out  8  register write data.
- oRegWrite  out  1  register write strobe, 1 cycle.
- oRegRead  out  1  register read strobe, 1 cycle.
- iRegRData  in  8  read data, sampled exactly 1 cycle after oRegRead.
- oBusy  out  1  high whenever state ≠ HUNT.
- oFrameErr  out  1  1-cycle pulse on checksum error, bad command, or timeout.

## Operation
- Frame in: SYNC(pSyncByte), CMD, ADDR, DATA, CHK; CHK = CMD ^ ADDR ^ DATA.
- CMD 8'h01 = write ADDR←DATA; 8'h02 = read ADDR (DATA ignored but required).
- Frame out: pRespByte, STATUS, RDATA. STATUS 8'h00 OK, 8'h01 checksum error, 8'h02 unknown CMD. RDATA = read value for OK read, else 8'h00.
- States: HUNT → CMD → ADDR → DATA → CHK → EXEC → (RDWAIT for read) → RESP0 → RESP1 → RESP2 → HUNT.
- HUNT: pops every byte; non-sync bytes discarded silently; sync byte → CMD.
- CMD/ADDR/DATA/CHK: each pops one byte and latches it, then advances.
- EXEC: checksum checked first (bad → STATUS 01, no strobe), then CMD (unknown → STATUS 02, no strobe). Valid write pulses oRegWrite and goes to RESP0. Valid read pulses oRegRead and goes to RDWAIT, which latches iRegRData.
- RESPn: push one response byte each, only when iTxFull=0; otherwise hold.
- Checksum/command errors still produce a response; timeouts produce none.

## Timing
- Reset values: all outputs 0, state HUNT, latched bytes and timeout counter 0. Reset mid-frame or mid-response discards everything; no partial response is completed.
- oRxRead asserts only when iRxEmpty=0 in a receive state. Never on two consecutive cycles, to allow the FIFO pointer/empty update. Byte latched on the same edge as the pop. Minimum 2 cycles per byte.
- oTxWrite obeys the same rule: only when iTxFull=0, never on consecutive cycles.
- oRegAddr/oRegWData stable from EXEC until the next frame's EXEC. Strobes are asserted in the cycle after CHK is popped.
- Latency, last CHK pop to first response push: 2 cycles for write, 3 for read (TX not full).
- Timeout: the counter runs in CMD..CHK, clears on each pop, and saturates. Reaching pTimeoutCycles-1 → oFrameErr pulse and return to HUNT. The timeout has priority over a pop in the same cycle.
- oFrameErr pulses in the EXEC cycle for checksum or command errors.
- A TX-full stall has no timeout. RX bytes arriving during EXEC..RESP2 stay in the RX FIFO.

## Configuration
- UART_CMD_PARSER_TIMEOUT_EN defined: inter-byte timeout logic present as above.
- Undefined: counter removed; the parser waits indefinitely in CMD..CHK; oFrameErr only signals checksum or command errors.

## Test plan
- RX A5 01 10 3C 2D → oRegWrite once with addr 8'h10, data 8'h3C. TX receives 5A 00 00.
- RX A5 02 22 00 20, iRegRData=8'h9B on the cycle after oRegRead → oRegRead once with addr 8'h22. TX receives 5A 00 9B.
- RX 00 FF A5 01 10 3C 00 (bad CHK) → garbage bytes dropped, no strobe, oFrameErr pulse. TX receives 5A 01 00.
- RX A5 07 01 02 04 → no strobe. TX receives 5A 02 00.
- RX A5 01 then silence for pTimeoutCycles (with the macro defined) → oFrameErr pulse and return to HUNT. No TX writes. A following valid frame is handled normally.
- Hold iTxFull=1 during a response → the response bytes are held, not lost. Asserting reset while in RESP1 → all outputs 0 and state HUNT on the next cycle.

Source files
------------

// File: rtl/uart_cmd_parser.sv
// Register-access command parser: assembles 5-byte frames from the RX FIFO, strobes the register bus,
// pushes a 3-byte response to the TX FIFO. Define UART_CMD_PARSER_TIMEOUT_EN to enable the inter-byte timeout.
module uart_cmd_parser #(
  parameter logic [7:0]  pSyncByte      = 8'hA5,
  parameter logic [7:0]  pRespByte      = 8'h5A,
  parameter int unsigned pTimeoutCycles = 120_000
) (
  input  logic       iClk,
  input  logic       iResetn,
  input  logic [7:0] iRxByte,
  input  logic       iRxEmpty,
  output logic       oRxRead,
  output logic [7:0] oTxByte,
  output logic       oTxWrite,
  input  logic       iTxFull,
  output logic [7:0] oRegAddr,
  output logic [7:0] oRegWData,
  output logic       oRegWrite,
  output logic       oRegRead,
  input  logic [7:0] iRegRData,
  output logic       oBusy,
  output logic       oFrameErr
);

  localparam logic [7:0] CMD_WRITE  = 8'h01;
  localparam logic [7:0] CMD_READ   = 8'h02;
  localparam logic [7:0] ST_OK      = 8'h00;
  localparam logic [7:0] ST_CHK_ERR = 8'h01;
  localparam logic [7:0] ST_CMD_ERR = 8'h02;

  typedef enum logic [3:0] {
    S_HUNT, S_CMD, S_ADDR, S_DATA, S_CHK, S_EXEC, S_RDWAIT, S_RESP0, S_RESP1, S_RESP2
  } state_t;

  state_t     state;
  logic [7:0] cmd_b, addr_b, data_b, chk_b;
  logic [7:0] status, rdata;
  logic       rx_pop;
  logic       tx_ok;
  logic       tmo_hit;

  // A pop or push needs a free FIFO and a gap cycle after the previous strobe.
  assign rx_pop = !iRxEmpty && !oRxRead;
  assign tx_ok  = !iTxFull && !oTxWrite;

`ifdef UART_CMD_PARSER_TIMEOUT_EN
  localparam int TW = (pTimeoutCycles > 2) ? $clog2(pTimeoutCycles) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(pTimeoutCycles - 1);

  logic [TW-1:0] tmo_cnt;
  logic          in_frame;

  assign in_frame = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA) || (state == S_CHK);
  assign tmo_hit  = in_frame && (tmo_cnt == TMO_LAST);

  // Inter-byte counter: runs while a frame is being received, cleared on every pop.
  always_ff @(posedge iClk) begin
    if (iResetn) begin
      tmo_cnt <= '0;
    end else if (in_frame && !rx_pop && !tmo_hit) begin
      tmo_cnt <= tmo_cnt + TW'(1);
    end else begin
      tmo_cnt <= '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
`endif

  // Main parser FSM; all outputs are registered here.
  always_ff @(posedge iClk) begin
    if (iResetn) begin
      state     <= S_HUNT;
      cmd_b     <= 8'h00;
      addr_b    <= 8'h00;
      data_b    <= 8'h00;
      chk_b     <= 8'h00;
      status    <= 8'h00;
      rdata     <= 8'h00;
      oRxRead   <= 1'b0;
      oTxByte   <= 8'h00;
      oTxWrite  <= 1'b0;
      oRegAddr  <= 8'h00;
      oRegWData <= 8'h00;
      oRegWrite <= 1'b0;
      oRegRead  <= 1'b0;
      oBusy     <= 1'b0;
      oFrameErr <= 1'b0;
    end else begin
      oRxRead   <= 1'b0;
      oTxWrite  <= 1'b0;
      oRegWrite <= 1'b0;
      oRegRead  <= 1'b0;
      oFrameErr <= 1'b0;
      case (state)
        S_HUNT: begin
          if (rx_pop) begin
            oRxRead <= 1'b1;
            if (iRxByte == pSyncByte) begin
              state <= S_CMD;
              oBusy <= 1'b1;
            end
          end
        end
        S_CMD, S_ADDR, S_DATA, S_CHK: begin
          // Timeout wins over a byte arriving in the same cycle.
          if (tmo_hit) begin
            oFrameErr <= 1'b1;
            state     <= S_HUNT;
            oBusy     <= 1'b0;
          end else if (rx_pop) begin
            oRxRead <= 1'b1;
            case (state)
              S_CMD:   begin cmd_b  <= iRxByte; state <= S_ADDR; end
              S_ADDR:  begin addr_b <= iRxByte; state <= S_DATA; end
              S_DATA:  begin data_b <= iRxByte; state <= S_CHK;  end
              default: begin chk_b  <= iRxByte; state <= S_EXEC; end
            endcase
          end
        end
        S_EXEC: begin
          oRegAddr  <= addr_b;
          oRegWData <= data_b;
          rdata     <= 8'h00;
          if ((cmd_b ^ addr_b ^ data_b) != chk_b) begin
            status    <= ST_CHK_ERR;
            oFrameErr <= 1'b1;
            state     <= S_RESP0;
          end else if (cmd_b == CMD_WRITE) begin
            status    <= ST_OK;
            oRegWrite <= 1'b1;
            state     <= S_RESP0;
          end else if (cmd_b == CMD_READ) begin
            status   <= ST_OK;
            oRegRead <= 1'b1;
            state    <= S_RDWAIT;
          end else begin
            status    <= ST_CMD_ERR;
            oFrameErr <= 1'b1;
            state     <= S_RESP0;
          end
        end
        S_RDWAIT: begin
          // Read data is valid the cycle after the strobe; the sync byte goes out on the same edge.
          if (!oRegRead) begin
            rdata <= iRegRData;
            if (tx_ok) begin
              oTxWrite <= 1'b1;
              oTxByte  <= pRespByte;
              state    <= S_RESP1;
            end else begin
              state <= S_RESP0;
            end
          end
        end
        S_RESP0: begin
          if (tx_ok) begin
            oTxWrite <= 1'b1;
            oTxByte  <= pRespByte;
            state    <= S_RESP1;
          end
        end
        S_RESP1: begin
          if (tx_ok) begin
            oTxWrite <= 1'b1;
            oTxByte  <= status;
            state    <= S_RESP2;
          end
        end
        S_RESP2: begin
          if (tx_ok) begin
            oTxWrite <= 1'b1;
            oTxByte  <= rdata;
            state    <= S_HUNT;
            oBusy    <= 1'b0;
          end
        end
        default: begin
          state <= S_HUNT;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: FIFO/register-bus models, scoreboard queues, vector table.
module tb_uart_cmd_parser;

  localparam int TMO = 16;

  logic       iClk = 1'b0;
  logic       iResetn = 1'b1;
  logic [7:0] iRxByte = 8'h00;
  logic       iRxEmpty = 1'b1;
  logic       oRxRead;
  logic [7:0] oTxByte;
  logic       oTxWrite;
  logic       iTxFull = 1'b0;
  logic [7:0] oRegAddr;
  logic [7:0] oRegWData;
  logic       oRegWrite;
  logic       oRegRead;
  logic [7:0] iRegRData = 8'hEE;
  logic       oBusy;
  logic       oFrameErr;

  uart_cmd_parser #(.pSyncByte(8'hA5), .pRespByte(8'h5A), .pTimeoutCycles(TMO)) dut (
    .iClk(iClk), .iResetn(iResetn), .iRxByte(iRxByte), .iRxEmpty(iRxEmpty), .oRxRead(oRxRead),
    .oTxByte(oTxByte), .oTxWrite(oTxWrite), .iTxFull(iTxFull), .oRegAddr(oRegAddr),
    .oRegWData(oRegWData), .oRegWrite(oRegWrite), .oRegRead(oRegRead), .iRegRData(iRegRData),
    .oBusy(oBusy), .oFrameErr(oFrameErr)
  );

  always #5 iClk = ~iClk;

  typedef struct {
    logic [7:0][7:0] b;
    int              len;
    bit              wr;
    bit              rd;
    logic [7:0]      addr;
    logic [7:0]      wdata;
    logic [7:0]      rval;
    logic [7:0]      status;
    logic [7:0]      rdata;
    int              ferr;
    int              lat;
  } vec_t;

  typedef struct packed {
    logic       rd;
    logic [7:0] addr;
    logic [7:0] data;
  } regop_t;

  logic [7:0] rx_q[$];
  logic [7:0] tx_exp[$];
  regop_t     reg_exp[$];

  int n_vec = 0, n_err = 0;
  int cyc = 0, last_pop_cyc = 0, lat_meas = -1;
  int tx_cnt = 0, wr_cnt = 0, rd_cnt = 0, ferr_cnt = 0;
  int rd_stage = 0;
  logic [7:0] rd_val = 8'h00;
  logic prev_rx = 1'b0, prev_tx = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // RX FIFO pops on the edge where oRxRead is high.
  always @(posedge iClk) begin
    if (oRxRead && rx_q.size() > 0) void'(rx_q.pop_front());
  end

  // Monitor: protocol checks and scoreboard, sampled mid-cycle.
  always @(negedge iClk) begin
    regop_t op;
    cyc++;
    if (rd_stage == 1) begin
      iRegRData = rd_val;
      rd_stage  = 2;
    end else if (rd_stage == 2) begin
      iRegRData = 8'hEE;
      rd_stage  = 0;
    end
    if (oRxRead) begin
      check("rx_gap", {31'd0, prev_rx}, 32'd0);
      check("rx_pop_nonempty", {31'd0, rx_q.size() != 0}, 32'd1);
      last_pop_cyc = cyc;
    end
    if (oTxWrite) begin
      check("tx_gap", {31'd0, prev_tx}, 32'd0);
      check("tx_not_full", {31'd0, iTxFull}, 32'd0);
      if (tx_exp.size() == 0) begin
        check("tx_unexpected", {24'd0, oTxByte}, 32'hFFFF_FFFF);
      end else begin
        if (tx_exp.size() == 3) lat_meas = cyc - last_pop_cyc;
        check("tx_byte", {24'd0, oTxByte}, {24'd0, tx_exp.pop_front()});
      end
      tx_cnt++;
    end
    if (oRegWrite || oRegRead) begin
      if (oRegWrite) wr_cnt++;
      if (oRegRead) rd_cnt++;
      if (reg_exp.size() == 0) begin
        check("reg_unexpected", {15'd0, oRegRead, oRegAddr, oRegWData}, 32'hFFFF_FFFF);
      end else begin
        op = reg_exp.pop_front();
        check("reg_kind", {30'd0, oRegRead, oRegWrite}, {30'd0, op.rd, !op.rd});
        check("reg_addr", {24'd0, oRegAddr}, {24'd0, op.addr});
        if (!op.rd) check("reg_wdata", {24'd0, oRegWData}, {24'd0, op.data});
        if (oRegRead) begin
          rd_val   = op.data;
          rd_stage = 1;
        end
      end
    end
    if (oFrameErr) ferr_cnt++;
    prev_rx  = oRxRead;
    prev_tx  = oTxWrite;
    iRxEmpty = (rx_q.size() == 0);
    iRxByte  = (rx_q.size() != 0) ? rx_q[0] : 8'h00;
  end

  function automatic vec_t mk(input logic [63:0] b, input int len, input bit wr, input bit rd,
                              input logic [7:0] addr, input logic [7:0] wdata, input logic [7:0] rval,
                              input logic [7:0] status, input logic [7:0] rdata, input int ferr,
                              input int lat);
    vec_t v;
    v.b = b; v.len = len; v.wr = wr; v.rd = rd; v.addr = addr; v.wdata = wdata; v.rval = rval;
    v.status = status; v.rdata = rdata; v.ferr = ferr; v.lat = lat;
    return v;
  endfunction

  function automatic logic is_idle();
    return (rx_q.size() == 0) && (tx_exp.size() == 0) && (reg_exp.size() == 0) && !oBusy;
  endfunction

  task automatic wait_idle(input int budget);
    int n = 0;
    do begin
      @(negedge iClk);
      n++;
    end while (!is_idle() && n < budget);
    check("idle_within_budget", {31'd0, is_idle()}, 32'd1);
  endtask

  task automatic expect_frame(input vec_t v);
    tx_exp.push_back(8'h5A);
    tx_exp.push_back(v.status);
    tx_exp.push_back(v.rdata);
    if (v.wr) reg_exp.push_back('{rd: 1'b0, addr: v.addr, data: v.wdata});
    if (v.rd) reg_exp.push_back('{rd: 1'b1, addr: v.addr, data: v.rval});
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int w0 = wr_cnt, r0 = rd_cnt, f0 = ferr_cnt;
    lat_meas = -1;
    expect_frame(v);
    for (int i = 0; i < v.len; i++) rx_q.push_back(v.b[7-i]);
    wait_idle(300);
    check($sformatf("v%0d_wr_count", idx), wr_cnt - w0, v.wr);
    check($sformatf("v%0d_rd_count", idx), rd_cnt - r0, v.rd);
    check($sformatf("v%0d_frame_err", idx), ferr_cnt - f0, v.ferr);
    check($sformatf("v%0d_latency", idx), lat_meas, v.lat);
  endtask

  function automatic logic [31:0] outs();
    return {2'd0, oRxRead, oTxByte, oTxWrite, oRegAddr, oRegWData, oRegWrite, oRegRead, oBusy, oFrameErr};
  endfunction

  vec_t vecs[8];

  initial begin
    int t0, hold, f0, w0, n;
    vecs[0] = mk(64'hA5_01_10_3C_2D_00_00_00, 5, 1, 0, 8'h10, 8'h3C, 8'h00, 8'h00, 8'h00, 0, 2);
    vecs[1] = mk(64'hA5_02_22_00_20_00_00_00, 5, 0, 1, 8'h22, 8'h00, 8'h9B, 8'h00, 8'h9B, 0, 3);
    vecs[2] = mk(64'h00_FF_A5_01_10_3C_00_00, 7, 0, 0, 8'h10, 8'h3C, 8'h00, 8'h01, 8'h00, 1, 2);
    vecs[3] = mk(64'hA5_07_01_02_04_00_00_00, 5, 0, 0, 8'h01, 8'h02, 8'h00, 8'h02, 8'h00, 1, 2);
    vecs[4] = mk(64'hA5_01_FF_00_FE_00_00_00, 5, 1, 0, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2);
    vecs[5] = mk(64'hA5_02_80_55_D7_00_00_00, 5, 0, 1, 8'h80, 8'h55, 8'h41, 8'h00, 8'h41, 0, 3);
    vecs[6] = mk(64'hA5_A5_01_02_A6_00_00_00, 5, 0, 0, 8'h01, 8'h02, 8'h00, 8'h02, 8'h00, 1, 2);
    vecs[7] = mk(64'hA5_02_33_00_00_00_00_00, 5, 0, 0, 8'h33, 8'h00, 8'h00, 8'h01, 8'h00, 1, 2);

    repeat (3) @(negedge iClk);
    check("reset_outputs", outs(), 32'd0);
    iResetn = 1'b0;
    repeat (2) @(negedge iClk);
    check("post_reset_outputs", outs(), 32'd0);

    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Inter-byte silence after SYNC CMD.
    f0 = ferr_cnt; t0 = tx_cnt; w0 = wr_cnt;
    rx_q.push_back(8'hA5);
    rx_q.push_back(8'h01);
`ifdef UART_CMD_PARSER_TIMEOUT_EN
    wait_idle(4 * TMO);
    check("timeout_frame_err", ferr_cnt - f0, 32'd1);
    check("timeout_no_tx", tx_cnt - t0, 32'd0);
    check("timeout_no_strobe", wr_cnt - w0, 32'd0);
    run_vec(vecs[0], 100);
`else
    repeat (4 * TMO) @(negedge iClk);
    check("no_timeout_busy", {31'd0, oBusy}, 32'd1);
    check("no_timeout_no_err", ferr_cnt - f0, 32'd0);
    expect_frame(vecs[0]);
    rx_q.push_back(8'h10);
    rx_q.push_back(8'h3C);
    rx_q.push_back(8'h2D);
    wait_idle(300);
    check("late_frame_write", wr_cnt - w0, 32'd1);
`endif

    // TX full stall mid-response: bytes held, not lost.
    t0 = tx_cnt;
    expect_frame(mk(64'hA5_01_44_99_DC_00_00_00, 5, 1, 0, 8'h44, 8'h99, 8'h00, 8'h00, 8'h00, 0, 2));
    rx_q.push_back(8'hA5); rx_q.push_back(8'h01); rx_q.push_back(8'h44);
    rx_q.push_back(8'h99); rx_q.push_back(8'hDC);
    n = 0;
    while (tx_cnt == t0 && n < 200) begin @(negedge iClk); n++; end
    check("stall_first_byte", {31'd0, tx_cnt != t0}, 32'd1);
    iTxFull = 1'b1;
    hold = tx_cnt;
    repeat (20) @(negedge iClk);
    check("stall_hold", tx_cnt, hold);
    check("stall_busy", {31'd0, oBusy}, 32'd1);
    iTxFull = 1'b0;
    wait_idle(100);
    check("stall_all_bytes", tx_cnt - t0, 32'd3);

    // Reset while the response is partly sent.
    t0 = tx_cnt;
    expect_frame(mk(64'hA5_02_10_00_12_00_00_00, 5, 0, 1, 8'h10, 8'h00, 8'h77, 8'h00, 8'h77, 0, 3));
    rx_q.push_back(8'hA5); rx_q.push_back(8'h02); rx_q.push_back(8'h10);
    rx_q.push_back(8'h00); rx_q.push_back(8'h12);
    n = 0;
    while (tx_cnt == t0 && n < 200) begin @(negedge iClk); n++; end
    iTxFull = 1'b1;
    repeat (3) @(negedge iClk);
    iResetn = 1'b1;
    @(negedge iClk);
    check("mid_resp_reset_outputs", outs(), 32'd0);
    iResetn = 1'b0;
    tx_exp.delete();
    check("mid_resp_read_done", reg_exp.size(), 32'd0);
    iTxFull = 1'b0;
    hold = tx_cnt;
    repeat (20) @(negedge iClk);
    check("mid_resp_no_completion", tx_cnt, hold);
    check("mid_resp_idle", {31'd0, oBusy}, 32'd0);

    run_vec(vecs[1], 101);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
